regfile_rd_arbiter: RTL and testbench

- Shares one register-file read port among NUM_REQ requesters, e.g. the ch_CFG FSM and the channel FSM.
- Replaces static mux/demux selection with per-cycle round-robin arbitration.
- Returns each read result to the requester that issued it, using a requester-ID pipeline matched to the register-file read latency.
- One instance per register-file read port.

---
 rtl/regfile_rd_arbiter_if.sv | 28 ++
 rtl/regfile_rd_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_rd_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_rd_arbiter_if.sv
// Requester-side and register-file-side signals of one shared register-file read port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface regfile_rd_arbiter_if #(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned REGFILE_ADDR_WIDTH = 8,
  parameter int unsigned REGFILE_DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                    req;
  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]                    req_lock;
  logic [NUM_REQ-1:0]                    gnt;
  logic [NUM_REQ-1:0]                    rvalid;
  logic [REGFILE_DATA_WIDTH-1:0]         rdata;
  logic                                  busy;
  logic                                  regFile_readEnable;
  logic [REGFILE_ADDR_WIDTH-1:0]         regFile_readAddr;
  logic [REGFILE_DATA_WIDTH-1:0]         regFile_readData;

  modport slave (
    input  req, req_addr, req_lock, regFile_readData,
    output gnt, rvalid, rdata, busy, regFile_readEnable, regFile_readAddr
  );

  modport master (
    output req, req_addr, req_lock, regFile_readData,
    input  gnt, rvalid, rdata, busy, regFile_readEnable, regFile_readAddr
  );
endinterface

// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Define RD_ARB_LOCK_EN to honour req_lock (LOCKED state); otherwise req_lock is ignored.
module regfile_rd_arbiter #(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned REGFILE_ADDR_WIDTH = 8,
  parameter int unsigned REGFILE_DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY         = 1
) (
  input logic                AXI_aclk,
  input logic                AXI_areset,
  regfile_rd_arbiter_if.slave bus
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  typedef logic [IdW-1:0] id_t;

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e                state_q;
  id_t                   rr_ptr_q;
  id_t                   owner_q;
  logic                  out_en_q;
  logic [RD_LATENCY-1:0] pipe_vld_q;
  id_t                   pipe_id_q [RD_LATENCY];

  logic win_vld;
  id_t  win_id;
  id_t  scan_id;
  logic grant;
  id_t  next_ptr;
  logic out_vld;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_id = id_t'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_vld && bus.req[scan_id] && (state_q == StArb || scan_id == owner_q)) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  // out_en_q keeps every output quiet during the first cycle after reset release.
  assign grant    = win_vld && out_en_q && !AXI_areset;
  assign next_ptr = (win_id == id_t'(NUM_REQ - 1)) ? '0 : win_id + id_t'(1);
  assign out_vld  = pipe_vld_q[RD_LATENCY-1] && !AXI_areset;

  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.gnt[i]    = grant && (win_id == id_t'(i));
      bus.rvalid[i] = out_vld && (pipe_id_q[RD_LATENCY-1] == id_t'(i));
    end
    bus.regFile_readEnable = grant;
    bus.regFile_readAddr   = grant ?
        bus.req_addr[32'(win_id)*REGFILE_ADDR_WIDTH +: REGFILE_ADDR_WIDTH] : '0;
    bus.rdata = out_vld ? bus.regFile_readData : '0;
    bus.busy  = !AXI_areset && (state_q == StLocked || |pipe_vld_q);
  end

  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      state_q    <= StArb;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      out_en_q   <= 1'b0;
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_id_q[i] <= '0;
      end
    end else begin
      out_en_q      <= 1'b1;
      pipe_vld_q[0] <= grant;
      pipe_id_q[0]  <= win_id;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
`ifdef RD_ARB_LOCK_EN
      unique case (state_q)
        StArb: begin
          if (grant) begin
            rr_ptr_q <= next_ptr;
            if (bus.req_lock[win_id]) begin
              state_q <= StLocked;
              owner_q <= win_id;
            end
          end
        end
        StLocked: begin
          // Release on the last locked read, or when the owner walks away without reading.
          if (grant) begin
            if (!bus.req_lock[owner_q]) state_q <= StArb;
          end else if (!bus.req[owner_q]) begin
            state_q <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
`else
      if (grant) rr_ptr_q <= next_ptr;
`endif
    end
  end

`ifndef RD_ARB_LOCK_EN
  logic unused_req_lock;
  assign unused_req_lock = ^bus.req_lock;
`endif

endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Self-checking bench: three arbiters (read latency 1, 2, 3) share one stimulus stream;
// a scoreboard per instance predicts rvalid/rdata/busy from the bench's own expectations.
module tb_regfile_rd_arbiter;

  localparam int Lat [3] = '{1, 2, 3};

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  lock = 2'b00;
  logic [15:0] addr = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          exp_locked = 1'b0;
  exp_t        sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_rd_arbiter_if #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32)) b1 ();
  regfile_rd_arbiter_if #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32)) b2 ();
  regfile_rd_arbiter_if #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32)) b3 ();

  assign b1.req = req;   assign b1.req_lock = lock;   assign b1.req_addr = addr;
  assign b2.req = req;   assign b2.req_lock = lock;   assign b2.req_addr = addr;
  assign b3.req = req;   assign b3.req_lock = lock;   assign b3.req_addr = addr;

  regfile_rd_arbiter #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32),
                       .RD_LATENCY(1)) u_dut1 (.AXI_aclk(clk), .AXI_areset(rst), .bus(b1.slave));
  regfile_rd_arbiter #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32),
                       .RD_LATENCY(2)) u_dut2 (.AXI_aclk(clk), .AXI_areset(rst), .bus(b2.slave));
  regfile_rd_arbiter #(.NUM_REQ(2), .REGFILE_ADDR_WIDTH(8), .REGFILE_DATA_WIDTH(32),
                       .RD_LATENCY(3)) u_dut3 (.AXI_aclk(clk), .AXI_areset(rst), .bus(b3.slave));

  function automatic logic [31:0] rf_data(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  // Register-file models with 1, 2 and 3 cycles of read latency; junk when not reading.
  logic       en1 = 1'b0;
  logic [7:0] ad1 = 8'h00;
  logic [1:0] en2 = 2'b00;
  logic [7:0] ad2 [2] = '{8'h00, 8'h00};
  logic [2:0] en3 = 3'b000;
  logic [7:0] ad3 [3] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    en1    <= b1.regFile_readEnable;
    ad1    <= b1.regFile_readAddr;
    en2    <= {en2[0], b2.regFile_readEnable};
    ad2[0] <= b2.regFile_readAddr;
    ad2[1] <= ad2[0];
    en3    <= {en3[1:0], b3.regFile_readEnable};
    ad3[0] <= b3.regFile_readAddr;
    ad3[1] <= ad3[0];
    ad3[2] <= ad3[1];
  end

  assign b1.regFile_readData = en1    ? rf_data(ad1)    : 32'hBAD0BAD0;
  assign b2.regFile_readData = en2[1] ? rf_data(ad2[1]) : 32'hBAD0BAD0;
  assign b3.regFile_readData = en3[2] ? rf_data(ad3[2]) : 32'hBAD0BAD0;

  logic [1:0]  rv [3];
  logic [31:0] rd [3];
  logic        bz [3];
  assign rv[0] = b1.rvalid;  assign rd[0] = b1.rdata;  assign bz[0] = b1.busy;
  assign rv[1] = b2.rvalid;  assign rd[1] = b2.rdata;  assign bz[1] = b2.busy;
  assign rv[2] = b3.rvalid;  assign rd[2] = b3.rdata;  assign bz[2] = b3.busy;

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   inflight;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        inflight = 1'b0;
        for (int j = 0; j < sbq[k].size(); j++) begin
          if (sbq[k][j].due >= cyc && sbq[k][j].due < cyc + Lat[k]) inflight = 1'b1;
        end
        checks++;
        if (bz[k] !== (inflight || exp_locked)) begin
          failures++;
          $display("FAIL busy lat%0d cyc=%0d: got %b expected %b", Lat[k], cyc, bz[k],
                   inflight || exp_locked);
        end
        if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
          e = sbq[k].pop_front();
          checks++;
          if (rv[k] !== (2'b01 << e.id) || rd[k] !== e.data) begin
            failures++;
            $display("FAIL rvalid lat%0d cyc=%0d: got rvalid=%b rdata=%h expected %b %h",
                     Lat[k], cyc, rv[k], rd[k], 2'b01 << e.id, e.data);
          end
        end else begin
          checks++;
          if (rv[k] !== 2'b00 || rd[k] !== 32'h0) begin
            failures++;
            $display("FAIL idle_rvalid lat%0d cyc=%0d: got rvalid=%b rdata=%h expected 00 0",
                     Lat[k], cyc, rv[k], rd[k]);
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] lk, input logic [7:0] a0,
                       input logic [7:0] a1);
    @(posedge clk);
    #1;
    req  = r;
    lock = lk;
    addr = {a1, a0};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic expect_read(input int id, input logic [7:0] a);
    for (int k = 0; k < 3; k++) sbq[k].push_back('{due: cyc + Lat[k], id: id, data: rf_data(a)});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 2'b00;
    lock = 2'b00;
    exp_locked = 1'b0;
    for (int k = 0; k < 3; k++) sbq[k].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 2'b11;
    addr = 16'h3130;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (b1.gnt !== 2'b00 || b3.gnt !== 2'b00 || b1.regFile_readEnable !== 1'b0 ||
          b1.regFile_readAddr !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs: got gnt=%b re=%b addr=%h expected 00 0 00",
                 b1.gnt, b1.regFile_readEnable, b1.regFile_readAddr);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b00 || b2.gnt !== 2'b00 || b1.regFile_readEnable !== 1'b0) begin
      failures++;
      $display("FAIL first_cycle_after_release: got gnt=%b re=%b expected 00 0",
               b1.gnt, b1.regFile_readEnable);
    end
    drive(2'b11, 2'b00, 8'h30, 8'h31);
    expect_read(0, 8'h30);
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b01 || b2.gnt !== 2'b01 || b3.gnt !== 2'b01 ||
        b1.regFile_readAddr !== 8'h30) begin
      failures++;
      $display("FAIL first_grant_ptr0: got gnt=%b addr=%h expected 01 30",
               b1.gnt, b1.regFile_readAddr);
    end
    idle(4);
  endtask

  task automatic test_single();
    drive(2'b01, 2'b00, 8'h10, 8'h00);
    expect_read(0, 8'h10);
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b01 || b2.gnt !== 2'b01 || b3.gnt !== 2'b01) begin
      failures++;
      $display("FAIL single_gnt: got %b expected 01", b1.gnt);
    end
    checks++;
    if (b1.regFile_readEnable !== 1'b1 || b1.regFile_readAddr !== 8'h10) begin
      failures++;
      $display("FAIL single_read_port: got re=%b addr=%h expected 1 10",
               b1.regFile_readEnable, b1.regFile_readAddr);
    end
    drive(2'b00, 2'b00, 8'h10, 8'h00);
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b00 || b1.regFile_readEnable !== 1'b0 || b1.regFile_readAddr !== 8'h00) begin
      failures++;
      $display("FAIL no_req_idle: got gnt=%b re=%b addr=%h expected 00 0 00",
               b1.gnt, b1.regFile_readEnable, b1.regFile_readAddr);
    end
    idle(4);
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    logic [7:0] ea;
    int         id;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 8'h20, 8'h31);
      id = exp_g[i][1] ? 1 : 0;
      ea = (id == 1) ? 8'h31 : 8'h20;
      expect_read(id, ea);
      @(negedge clk);
      checks++;
      if (b1.gnt !== exp_g[i] || b2.gnt !== exp_g[i] || b3.gnt !== exp_g[i]) begin
        failures++;
        $display("FAIL contention_gnt[%0d]: got %b expected %b", i, b1.gnt, exp_g[i]);
      end
      checks++;
      if (b1.regFile_readEnable !== 1'b1 || b1.regFile_readAddr !== ea) begin
        failures++;
        $display("FAIL contention_addr[%0d]: got re=%b addr=%h expected 1 %h", i,
                 b1.regFile_readEnable, b1.regFile_readAddr, ea);
      end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [1:0] pat [3];
    logic [7:0] a0 [3];
    logic [7:0] ea;
    pat = '{2'b01, 2'b10, 2'b01};
    a0  = '{8'h50, 8'h51, 8'h52};
    for (int i = 0; i < 3; i++) begin
      drive(pat[i], 2'b00, a0[i], 8'h61);
      ea = pat[i][1] ? 8'h61 : a0[i];
      expect_read(pat[i][1] ? 1 : 0, ea);
      @(negedge clk);
      checks++;
      if (b1.gnt !== pat[i] || b3.gnt !== pat[i] || b3.regFile_readAddr !== ea) begin
        failures++;
        $display("FAIL b2b_gnt[%0d]: got gnt=%b addr=%h expected %b %h", i, b3.gnt,
                 b3.regFile_readAddr, pat[i], ea);
      end
    end
    idle(5);
  endtask

  task automatic test_reset_midflight();
    drive(2'b01, 2'b00, 8'h44, 8'h00);
    expect_read(0, 8'h44);
    @(negedge clk);
    checks++;
    if (b2.gnt !== 2'b01) begin
      failures++;
      $display("FAIL midflight_gnt: got %b expected 01", b2.gnt);
    end
    do_reset();
    req  = 2'b11;
    addr = 16'h4544;
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b00 || b2.gnt !== 2'b00 || b2.regFile_readEnable !== 1'b0) begin
      failures++;
      $display("FAIL midflight_release_quiet: got gnt=%b re=%b expected 00 0",
               b2.gnt, b2.regFile_readEnable);
    end
    drive(2'b11, 2'b00, 8'h44, 8'h45);
    expect_read(0, 8'h44);
    @(negedge clk);
    checks++;
    if (b1.gnt !== 2'b01 || b2.gnt !== 2'b01 || b3.gnt !== 2'b01) begin
      failures++;
      $display("FAIL midflight_ptr_reset: got %b expected 01", b2.gnt);
    end
    idle(5);
  endtask

`ifdef RD_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] r  [9];
    logic [1:0] lk [9];
    logic [1:0] eg [9];
    bit         el [9];
    r  = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01};
    lk = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    eg = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
    el = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(r[i], lk[i], 8'h70, 8'h71);
      exp_locked = el[i];
      if (eg[i] != 2'b00) expect_read(eg[i][1] ? 1 : 0, eg[i][1] ? 8'h71 : 8'h70);
      @(negedge clk);
      checks++;
      if (b1.gnt !== eg[i] || b2.gnt !== eg[i] || b3.gnt !== eg[i]) begin
        failures++;
        $display("FAIL lock_gnt[%0d]: got %b expected %b", i, b1.gnt, eg[i]);
      end
    end
    exp_locked = 1'b0;
    idle(5);
  endtask
`else
  task automatic test_lock_disabled();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b10, 8'h80, 8'h81);
      expect_read(exp_g[i][1] ? 1 : 0, exp_g[i][1] ? 8'h81 : 8'h80);
      @(negedge clk);
      checks++;
      if (b1.gnt !== exp_g[i] || b2.gnt !== exp_g[i] || b3.gnt !== exp_g[i]) begin
        failures++;
        $display("FAIL nolock_gnt[%0d]: got %b expected %b", i, b1.gnt, exp_g[i]);
      end
    end
    idle(5);
  endtask
`endif

  initial begin
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_midflight();
`ifdef RD_ARB_LOCK_EN
    test_lock();
`else
    test_lock_disabled();
`endif
    idle(2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sbq[k].size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain lat%0d: got %0d pending expected 0", Lat[k],
                 sbq[k].size());
      end
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
